// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender with a registered output stage
// and a one-entry skid buffer on a valid/ready handshake.
module imm_ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [IN_W-1:0]  imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       out_mode
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int PAD = OUT_W - IN_W;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [OUT_W-1:0] r_out_data;
    logic [OUT_W-1:0] w_out_data_nxt;
    logic [1:0]       r_out_mode;
    logic [1:0]       w_out_mode_nxt;
    logic [OUT_W-1:0] r_sk_data;
    logic [OUT_W-1:0] w_sk_data_nxt;
    logic [1:0]       r_sk_mode;
    logic [1:0]       w_sk_mode_nxt;

    logic [OUT_W-1:0] w_zx;
    logic [OUT_W-1:0] w_sx;
    logic [OUT_W-1:0] w_up;
    logic [OUT_W-1:0] w_br;
    logic [OUT_W-1:0] w_ext;
    logic             w_acc;
    logic             w_drn;
    logic             w_sk_valid;

    assign w_zx = {{PAD{1'b0}}, imm};
    assign w_sx = {{PAD{imm[IN_W-1]}}, imm};
    assign w_up = {imm, {PAD{1'b0}}};
    assign w_br = {w_sx[OUT_W-3:0], 2'b00};

    // Select the extended operand for the incoming mode
    always_comb begin
        w_ext = w_zx;
        case (mode)
            2'b00:   w_ext = w_zx;
            2'b01:   w_ext = w_sx;
            2'b10:   w_ext = w_up;
            2'b11:   w_ext = w_br;
            default: w_ext = w_zx;
        endcase
    end

    // Skid occupancy gates the input; reset forces not-ready
    assign w_sk_valid = (r_state == FULL);
    assign in_ready   = !w_sk_valid && !rst;
    assign out_valid  = (r_state != EMPTY);
    assign out_data   = r_out_data;
    assign out_mode   = r_out_mode;

    assign w_acc = in_valid && in_ready;
    assign w_drn = out_valid && out_ready;

    // Next-state and storage updates for EMPTY/ONE/FULL
    always_comb begin
        w_state_nxt    = r_state;
        w_out_data_nxt = r_out_data;
        w_out_mode_nxt = r_out_mode;
        w_sk_data_nxt  = r_sk_data;
        w_sk_mode_nxt  = r_sk_mode;
        case (r_state)
            EMPTY: begin
                if (w_acc) begin
                    w_state_nxt    = ONE;
                    w_out_data_nxt = w_ext;
                    w_out_mode_nxt = mode;
                end
            end
            ONE: begin
                if (w_acc && w_drn) begin
                    w_out_data_nxt = w_ext;
                    w_out_mode_nxt = mode;
                end else if (w_acc) begin
                    w_state_nxt   = FULL;
                    w_sk_data_nxt = w_ext;
                    w_sk_mode_nxt = mode;
                end else if (w_drn) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_drn) begin
                    w_state_nxt    = ONE;
                    w_out_data_nxt = r_sk_data;
                    w_out_mode_nxt = r_sk_mode;
                    w_sk_data_nxt  = '0;
                    w_sk_mode_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
    end

    // State and data registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_out_data <= '0;
            r_out_mode <= '0;
            r_sk_data  <= '0;
            r_sk_mode  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_out_data <= w_out_data_nxt;
            r_out_mode <= w_out_mode_nxt;
            r_sk_data  <= w_sk_data_nxt;
            r_sk_mode  <= w_sk_mode_nxt;
        end
    end

endmodule
